// File: rtl/depth_test_writer.sv
// Z-buffer test and framebuffer writer: one pixel per cycle, with in-flight depth
// forwarding so results match strictly sequential processing. Also owns the frame clear sweep.
module depth_test_writer #(
  parameter int COORD_WIDTH     = 32,
  parameter int DEPTH_BIT_WIDTH = 16,
  parameter int COLOR_WIDTH     = 16,
  parameter int FB_WIDTH        = 320,
  parameter int FB_HEIGHT       = 180,
  parameter int READ_LATENCY    = 2,
  parameter int ADDR_WIDTH      = $clog2(FB_WIDTH*FB_HEIGHT)
) (
  input  logic                          clk_in,
  input  logic                          rst_in_n,
  input  logic                          pix_valid_in,
  input  logic signed [COORD_WIDTH-1:0] x_in,
  input  logic signed [COORD_WIDTH-1:0] y_in,
  input  logic [DEPTH_BIT_WIDTH-1:0]    depth_in,
  input  logic [COLOR_WIDTH-1:0]        color_in,
  input  logic                          clear_in,
  input  logic [COLOR_WIDTH-1:0]        clear_color_in,
  output logic                          ready_out,
  output logic                          busy_out,
  output logic                          clear_done_out,
  output logic [ADDR_WIDTH-1:0]         zb_raddr_out,
  input  logic [DEPTH_BIT_WIDTH-1:0]    zb_rdata_in,
  output logic                          zb_we_out,
  output logic [ADDR_WIDTH-1:0]         zb_waddr_out,
  output logic [DEPTH_BIT_WIDTH-1:0]    zb_wdata_out,
  output logic                          fb_we_out,
  output logic [ADDR_WIDTH-1:0]         fb_addr_out,
  output logic [COLOR_WIDTH-1:0]        fb_data_out,
  output logic [31:0]                   pass_count_out,
  output logic [31:0]                   reject_count_out,
  output logic [31:0]                   drop_count_out,
  output logic [1:0]                    state_out
);

  localparam int L = READ_LATENCY;
  localparam logic [1:0] S_RUN   = 2'd0;
  localparam logic [1:0] S_DRAIN = 2'd1;
  localparam logic [1:0] S_CLEAR = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;
  localparam logic [ADDR_WIDTH-1:0] FB_W_A = ADDR_WIDTH'(FB_WIDTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_A = ADDR_WIDTH'(FB_WIDTH*FB_HEIGHT-1);

  // Handshake: a pixel transfers on a rising edge where pix_valid_in && ready_out;
  // there is no backpressure beyond ready_out, and a valid without ready is dropped and counted.

  logic [1:0] rst_sync;
  logic       rst_n;
  always_ff @(posedge clk_in or negedge rst_in_n) begin
    if (!rst_in_n) rst_sync <= 2'b00;
    else           rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n = rst_sync[1];

  logic [1:0]                 state;
  logic [ADDR_WIDTH-1:0]      clr_addr;
  logic [COLOR_WIDTH-1:0]     clr_color;
  logic [31:0]                pass_cnt, rej_cnt, drop_cnt;

  // Stages 0..L wait for read data; d_* holds a decided pass, w_* drives the write ports,
  // h_* remembers writes that committed after younger reads were already issued.
  logic                       p_v     [0:L];
  logic [ADDR_WIDTH-1:0]      p_addr  [0:L];
  logic [DEPTH_BIT_WIDTH-1:0] p_depth [0:L];
  logic [COLOR_WIDTH-1:0]     p_color [0:L];
  logic                       d_v, w_v;
  logic [ADDR_WIDTH-1:0]      d_addr, w_addr;
  logic [DEPTH_BIT_WIDTH-1:0] d_depth, w_depth;
  logic [COLOR_WIDTH-1:0]     d_color, w_color;
  logic                       h_v     [0:L-1];
  logic [ADDR_WIDTH-1:0]      h_addr  [0:L-1];
  logic [DEPTH_BIT_WIDTH-1:0] h_depth [0:L-1];

  logic                       in_range, accept, pipe_busy, pass_now;
  logic [ADDR_WIDTH-1:0]      in_addr;
  logic [DEPTH_BIT_WIDTH-1:0] stored;

  assign in_range = (x_in >= 0) && (x_in < $signed(COORD_WIDTH'(FB_WIDTH))) &&
                    (y_in >= 0) && (y_in < $signed(COORD_WIDTH'(FB_HEIGHT)));
  assign accept   = pix_valid_in && ready_out;
  assign in_addr  = y_in[ADDR_WIDTH-1:0] * FB_W_A + x_in[ADDR_WIDTH-1:0];

  always_comb begin
    pipe_busy = d_v || w_v;
    for (int i = 0; i <= L; i++) pipe_busy = pipe_busy || p_v[i];
  end

  // Oldest match first so the newest in-flight pass to the address wins.
  always_comb begin
    stored = zb_rdata_in;
    for (int i = L-1; i >= 0; i--)
      if (h_v[i] && h_addr[i] == p_addr[L]) stored = h_depth[i];
    if (w_v && w_addr == p_addr[L]) stored = w_depth;
    if (d_v && d_addr == p_addr[L]) stored = d_depth;
  end
  assign pass_now = p_v[L] && (p_depth[L] < stored);

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i <= L; i++) begin
        p_v[i] <= 1'b0; p_addr[i] <= '0; p_depth[i] <= '0; p_color[i] <= '0;
      end
      for (int i = 0; i < L; i++) begin
        h_v[i] <= 1'b0; h_addr[i] <= '0; h_depth[i] <= '0;
      end
      d_v <= 1'b0; d_addr <= '0; d_depth <= '0; d_color <= '0;
      w_v <= 1'b0; w_addr <= '0; w_depth <= '0; w_color <= '0;
    end else begin
      p_v[0]     <= accept && in_range;
      p_addr[0]  <= in_addr;
      p_depth[0] <= depth_in;
      p_color[0] <= color_in;
      for (int i = 1; i <= L; i++) begin
        p_v[i] <= p_v[i-1]; p_addr[i] <= p_addr[i-1];
        p_depth[i] <= p_depth[i-1]; p_color[i] <= p_color[i-1];
      end
      d_v <= pass_now; d_addr <= p_addr[L]; d_depth <= p_depth[L]; d_color <= p_color[L];
      w_v <= d_v; w_addr <= d_addr; w_depth <= d_depth; w_color <= d_color;
      h_v[0] <= w_v; h_addr[0] <= w_addr; h_depth[0] <= w_depth;
      for (int i = 1; i < L; i++) begin
        h_v[i] <= h_v[i-1]; h_addr[i] <= h_addr[i-1]; h_depth[i] <= h_depth[i-1];
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_RUN;
      clr_addr  <= '0;
      clr_color <= '0;
      pass_cnt  <= '0;
      rej_cnt   <= '0;
      drop_cnt  <= '0;
    end else begin
      if (pix_valid_in && !ready_out && drop_cnt != '1) drop_cnt <= drop_cnt + 32'd1;
      if (p_v[L]) begin
        if (pass_now) begin
          if (pass_cnt != '1) pass_cnt <= pass_cnt + 32'd1;
        end else if (rej_cnt != '1) begin
          rej_cnt <= rej_cnt + 32'd1;
        end
      end
      case (state)
        S_RUN: if (clear_in) begin
          clr_color <= clear_color_in;
          state     <= S_DRAIN;
        end
        S_DRAIN: if (!pipe_busy) begin
          clr_addr <= '0;
          state    <= S_CLEAR;
        end
        S_CLEAR: if (clr_addr == LAST_A) begin
          pass_cnt <= '0;
          rej_cnt  <= '0;
          state    <= S_DONE;
        end else begin
          clr_addr <= clr_addr + 1'b1;
        end
        default: state <= S_RUN;
      endcase
    end
  end

  assign ready_out        = (state == S_RUN) || (state == S_DONE);
  assign busy_out         = pipe_busy || (state != S_RUN);
  assign clear_done_out   = (state == S_DONE);
  assign zb_raddr_out     = p_addr[0];
  assign zb_we_out        = (state == S_CLEAR) || w_v;
  assign zb_waddr_out     = (state == S_CLEAR) ? clr_addr : w_addr;
  assign zb_wdata_out     = (state == S_CLEAR) ? '1 : w_depth;
  assign fb_we_out        = zb_we_out;
  assign fb_addr_out      = zb_waddr_out;
  assign fb_data_out      = (state == S_CLEAR) ? clr_color : w_color;
  assign pass_count_out   = pass_cnt;
  assign reject_count_out = rej_cnt;
  assign drop_count_out   = drop_cnt;
  assign state_out        = state;

endmodule

// File: tb/tb_depth_test_writer.sv
// Bench for depth_test_writer: sequential z-buffer model with a timed write queue,
// a behavioural depth BRAM, and directed plus random pixel traffic.
module tb_depth_test_writer;

  localparam int W = 320;
  localparam int H = 180;
  localparam int N = W*H;
  localparam int L = 2;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               pix_valid;
  logic signed [31:0] px, py;
  logic [15:0]        pdepth, pcolor;
  logic               clear, ready, busy, clear_done;
  logic [15:0]        clear_color;
  logic [15:0]        zb_raddr, zb_rdata, zb_waddr, zb_wdata, fb_addr, fb_data;
  logic               zb_we, fb_we;
  logic [31:0]        pass_cnt, rej_cnt, drop_cnt;
  logic [1:0]         state_dbg;

  int n_checks = 0;
  int n_fail   = 0;

  depth_test_writer dut (
    .clk_in(clk), .rst_in_n(rst_n), .pix_valid_in(pix_valid), .x_in(px), .y_in(py),
    .depth_in(pdepth), .color_in(pcolor), .clear_in(clear), .clear_color_in(clear_color),
    .ready_out(ready), .busy_out(busy), .clear_done_out(clear_done),
    .zb_raddr_out(zb_raddr), .zb_rdata_in(zb_rdata), .zb_we_out(zb_we),
    .zb_waddr_out(zb_waddr), .zb_wdata_out(zb_wdata), .fb_we_out(fb_we),
    .fb_addr_out(fb_addr), .fb_data_out(fb_data), .pass_count_out(pass_cnt),
    .reject_count_out(rej_cnt), .drop_count_out(drop_cnt), .state_out(state_dbg)
  );

  always #5 clk = ~clk;

  // Depth BRAM, two-cycle read latency, read returns the pre-write contents.
  logic [15:0] zb_mem [0:N-1];
  logic [15:0] rd0 = '0, rd1 = '0;
  logic        mem_init = 1'b0;
  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < N; i++) zb_mem[i] = 16'($urandom);
      mem_init = 1'b1;
    end
    rd0 <= (int'(zb_raddr) < N) ? zb_mem[zb_raddr] : 16'h0;
    rd1 <= rd0;
    if (zb_we && int'(zb_waddr) < N) zb_mem[zb_waddr] = zb_wdata;
  end
  assign zb_rdata = rd1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- model + per-cycle compare ----------------
  logic [15:0] zmem [0:N-1];
  logic [79:0] exp_q [$];   // {due cycle, addr, depth, color}
  int          ncnt = 0, mode = 0, clr_idx = 0, clr_start = 0, drain_cyc = 0, quiet = 0;
  logic [15:0] m_clr_color = '0;
  int          m_pass = 0, m_rej = 0, m_drop = 0;
  bit          in_done;

  always @(negedge clk) begin
    ncnt++;
    in_done = 1'b0;
    if (!rst_n) begin
      exp_q.delete();
      mode = 0; m_pass = 0; m_rej = 0; m_drop = 0; quiet = 0;
      chk("rst_zb_we", zb_we, 0);
      chk("rst_fb_we", fb_we, 0);
      chk("rst_done", clear_done, 0);
      chk("rst_busy", busy, 0);
      chk("rst_ready", ready, 1);
      chk("rst_counts", {pass_cnt, rej_cnt | drop_cnt}, 0);
    end else begin
      if (mode == 3) begin
        chk("clear_done", clear_done, 1);
        chk("clear_done_cycle", 64'(ncnt - clr_start), 64'(N));
        m_pass = 0; m_rej = 0; mode = 0; in_done = 1'b1;
      end else begin
        chk("no_clear_done", clear_done, 0);
      end

      if (mode == 1 && exp_q.size() == 0 && zb_we) begin
        mode = 2; clr_idx = 0; clr_start = ncnt;
      end
      if (mode == 2) begin
        chk("clr_we", {zb_we, fb_we}, 2'b11);
        chk("clr_zaddr", zb_waddr, 64'(clr_idx));
        chk("clr_faddr", fb_addr, 64'(clr_idx));
        chk("clr_zdata", zb_wdata, 16'hFFFF);
        chk("clr_fdata", fb_data, m_clr_color);
        zmem[clr_idx] = 16'hFFFF;
        clr_idx++;
        if (clr_idx == N) mode = 3;
      end else if (exp_q.size() > 0 && int'(exp_q[0][79:48]) == ncnt) begin
        chk("pix_we", {zb_we, fb_we}, 2'b11);
        chk("pix_zaddr", zb_waddr, exp_q[0][47:32]);
        chk("pix_faddr", fb_addr, exp_q[0][47:32]);
        chk("pix_zdata", zb_wdata, exp_q[0][31:16]);
        chk("pix_fdata", fb_data, exp_q[0][15:0]);
        void'(exp_q.pop_front());
      end else if (zb_we || fb_we) begin
        chk("unexpected_write", {zb_we, fb_we}, 2'b00);
      end

      if (mode != 0) begin
        chk("ready_low", ready, 0);
        chk("busy_high", busy, 1);
      end else begin
        chk("ready_high", ready, 1);
      end
      if (mode == 1) begin
        drain_cyc++;
        if (drain_cyc == 21) chk("drain_len", 64'(drain_cyc), 20);
      end

      if (pix_valid) begin
        quiet = 0;
        if (mode == 0) begin
          if (px >= 0 && px < W && py >= 0 && py < H) begin
            int a;
            a = int'(py) * W + int'(px);
            if (pdepth < zmem[a]) begin
              zmem[a] = pdepth;
              exp_q.push_back({32'(ncnt + L + 3), 16'(a), pdepth, pcolor});
              m_pass++;
            end else begin
              m_rej++;
            end
          end
        end else begin
          m_drop++;
        end
      end else begin
        quiet++;
      end

      if (mode == 0 && clear && !in_done) begin
        mode = 1; m_clr_color = clear_color; drain_cyc = 0;
      end

      if (quiet >= L + 6 && exp_q.size() == 0 && mode != 1) begin
        chk("pass_count", pass_cnt, 64'(m_pass));
        chk("reject_count", rej_cnt, 64'(m_rej));
        chk("drop_count", drop_cnt, 64'(m_drop));
        if (mode == 0 && !in_done) chk("busy_idle", busy, 0);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    pix_valid = 1'b0;
    clear     = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_pix(input int x, input int y, input logic [15:0] d, input logic [15:0] c);
    pix_valid = 1'b1; px = x; py = y; pdepth = d; pcolor = c;
    @(posedge clk); #1;
    pix_valid = 1'b0;
  endtask

  task automatic do_clear_full(input logic [15:0] c);
    bit got;
    got = 1'b0;
    clear = 1'b1; clear_color = c;
    @(posedge clk); #1;
    clear = 1'b0;
    for (int i = 0; i < N + 100; i++) begin
      @(negedge clk);
      if (clear_done) begin got = 1'b1; break; end
    end
    chk("clear_done_wait", got, 1);
    @(posedge clk); #1;
  endtask

  initial begin
    int lat;
    bit got;
    int xs[7];
    int ys[6];
    xs = '{-1, 0, 1, 2, 3, 319, 320};
    ys = '{-1, 0, 1, 2, 179, 180};
    rst_n = 1'b0; pix_valid = 1'b0; px = 0; py = 0; pdepth = '0; pcolor = '0;
    clear = 1'b0; clear_color = '0;
    repeat (3) @(posedge clk); #1;
    rst_n = 1'b1;
    idle(6);
    chk("init_ready", ready, 1);

    // full clear to black
    do_clear_full(16'h0000);
    idle(4);
    chk("post_clear_counts", {pass_cnt, rej_cnt}, 0);
    chk("zb_first", zb_mem[0], 16'hFFFF);
    chk("zb_last", zb_mem[N-1], 16'hFFFF);

    // single pixel, latency
    send_pix(10, 5, 16'h1000, 16'hF800);
    lat = -1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (fb_we && lat < 0) begin
        lat = k - 1;
        chk("px1_addr", fb_addr, 16'd1610);
        chk("px1_data", fb_data, 16'hF800);
      end
    end
    chk("px1_latency", 64'(lat), 64'(4));
    idle(4);
    chk("px1_pass", pass_cnt, 1);

    // back-to-back same address
    pix_valid = 1'b1; px = 20; py = 8;
    pdepth = 16'h2000; pcolor = 16'h0001; @(posedge clk); #1;
    pdepth = 16'h1000; pcolor = 16'h0002; @(posedge clk); #1;
    pdepth = 16'h1800; pcolor = 16'h0003; @(posedge clk); #1;
    idle(12);
    chk("b2b_pass", pass_cnt, 3);
    chk("b2b_reject", rej_cnt, 1);
    chk("b2b_zb", zb_mem[8*W+20], 16'h1000);

    // out of range
    send_pix(-1, 0, 16'h0000, 16'h1111);
    send_pix(320, 0, 16'h0000, 16'h1111);
    send_pix(0, 180, 16'h0000, 16'h1111);
    idle(12);
    chk("oor_counts", {pass_cnt, rej_cnt, drop_cnt}, {32'd3, 32'd1, 32'd0});

    // random traffic with heavy address reuse
    for (int i = 0; i < 1500; i++) begin
      pix_valid = ($urandom_range(0, 9) < 7);
      px = xs[$urandom_range(0, 6)];
      py = ys[$urandom_range(0, 5)];
      pdepth = 16'($urandom_range(0, 1023));
      pcolor = 16'($urandom);
      @(posedge clk); #1;
    end
    idle(12);

    // clear with three pixels in flight, drop during clear, reset mid-sweep
    send_pix(100, 100, 16'h0005, 16'hAAA1);
    pix_valid = 1'b1; px = 101; pdepth = 16'h0005; pcolor = 16'hAAA2; @(posedge clk); #1;
    pix_valid = 1'b1; px = 102; pdepth = 16'h0005; pcolor = 16'hAAA3; @(posedge clk); #1;
    pix_valid = 1'b0;
    clear = 1'b1; clear_color = 16'h07E0;
    @(posedge clk); #1;
    clear = 1'b0;
    chk("drain_ready_low", ready, 0);
    got = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (zb_we && zb_waddr == 16'd0) begin got = 1'b1; break; end
    end
    chk("sweep_start", got, 1);
    @(posedge clk); #1;
    pix_valid = 1'b1; px = 5; py = 5; pdepth = 16'h0001; pcolor = 16'h1234; clear = 1'b1;
    @(posedge clk); #1;
    pix_valid = 1'b0; clear = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (zb_we && zb_waddr == 16'd100) begin got = 1'b1; break; end
    end
    chk("sweep_at_100", got, 1);
    chk("drop_one", drop_cnt, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("midclr_rst_we", {zb_we, fb_we}, 0);
    chk("midclr_rst_outs", {busy, clear_done, pass_cnt, rej_cnt, drop_cnt}, 0);
    chk("midclr_rst_ready", ready, 1);
    repeat (3) @(posedge clk); #1;
    rst_n = 1'b1;
    idle(20);
    chk("post_rst_ready", ready, 1);
    chk("post_rst_idle", {busy, zb_we, fb_we}, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
